reduction_adder_checker: RTL and testbench
==========================================

# reduction_adder_checker

Synchronous vector sweeper and response checker for the 4-bit reduction-gate and adder datapath (AND, OR, XOR reductions plus the 4-bit ripple adder with carry-in tied low). On `start` it drives every A pattern 0..2^WIDTH-1 together with a latched B operand into the units under check. It samples their responses, compares each against internally computed expected values, and reports error count, first-failure index and mismatch mask. It is the on-chip checking end of the stimulus interface the gate and adder units consume.

## Interface
- `WIDTH`, 4: operand width; sweep covers 2^WIDTH A values.
- `SETTLE`, 1: cycles each vector is held before its sampling cycle; legal range ≥ 1.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; one clock is decided for the whole block.
- `start` input 1: begin sweep; honoured only in IDLE.
- `b_cfg` input WIDTH: B operand; latched on accepted `start`.
- `and_in` input 1: DUT reduction-AND of `a_out`.
- `or_in` input 1: DUT reduction-OR of `a_out`.
- `xor_in` input 1: DUT reduction-XOR of `a_out`.
- `sum_in` input WIDTH: DUT adder sum of `a_out + b_out + 0`.
- `carry_in` input 1: DUT adder carry-out.
- `a_out` output WIDTH: current A vector to DUTs.
- `b_out` output WIDTH: latched B to DUTs.
- `busy` output 1: sweep in progress (DRIVE or SAMPLE).
- `done` output 1: one-cycle pulse at sweep end.
- `pass` output 1: 1 when the last completed sweep had zero errors; held until next accepted start.
- `err_count` output WIDTH+1: number of failing vectors; range 0..2^WIDTH.
- `fail_idx` output WIDTH: A value of the first failing vector.
- `fail_mask` output 5: mismatch bits of first failure: [0] and, [1] or, [2] xor, [3] sum (any bit), [4] carry.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: `busy`=0. When `start`=1, latch `b_cfg` into `b_out`, clear `a_out`, `err_count`, `fail_idx`, `fail_mask` and `pass`, load settle counter = SETTLE, and go to DRIVE.
- DRIVE: decrement settle counter. When it reaches 1, go to SAMPLE. `a_out` and `b_out` are stable throughout.
- SAMPLE: compare the inputs with the expected values:
  - exp_and = &a_out; exp_or = |a_out; exp_xor = ^a_out.
  - {exp_carry, exp_sum} = a_out + b_out, computed WIDTH+1 bits wide with no wrap before extraction.
  - Any mismatch increments `err_count`. If this is the first failure, capture `fail_idx`=`a_out` and `fail_mask`.
  - If `a_out` = 2^WIDTH-1, go to DONE. Otherwise increment `a_out` and return to DRIVE with the counter reloaded.
- DONE: `done`=1 for exactly one cycle, `pass` = (`err_count`==0), then IDLE. `a_out`, `b_out` and the results are held.
- `start` is ignored while in DRIVE, SAMPLE or DONE. A `start` level held high restarts only once the block is back in IDLE.
- `a_out` never wraps during a sweep; the terminal vector ends the sweep.
- `err_count` cannot overflow: its maximum is 2^WIDTH, which fits in WIDTH+1 bits.

## Timing
- Reset values: all outputs 0, state IDLE, latched B 0.
- `reset` has priority over every other input in any state. Asserting it mid-sweep aborts the sweep, zeroes all outputs including `pass`, and does not produce a `done` pulse.
- `start` sampled at edge E0 gives `busy`=1 and `a_out`=0 from E0.
- Each vector occupies SETTLE+1 cycles. Responses are compared at the edge that ends the SAMPLE cycle.
- The sweep occupies 2^WIDTH·(SETTLE+1) cycles. `done` is high in the following cycle. `busy` is 0 during DONE.
- Defaults: `busy` is high for 32 cycles and `done` is asserted in cycle 33 after E0.
- Updates to `err_count` and the `fail_*` outputs are visible the cycle after the SAMPLE edge.

## Test plan
- Ideal DUT model, `b_cfg`=4'b1011, start -> `done` pulse 33 cycles after start, `pass`=1, `err_count`=0, `fail_mask`=0.
- `and_in` stuck 0, `b_cfg`=0 -> `err_count`=1, `fail_idx`=4'hF, `fail_mask`=5'b00001, `pass`=0.
- `carry_in` stuck 0, `b_cfg`=4'b1011 -> failures at A=5..15: `err_count`=11, `fail_idx`=5, `fail_mask`=5'b10000.
- `or_in` stuck 1, `b_cfg`=0 -> `err_count`=1, `fail_idx`=0, `fail_mask`=5'b00010.
- `reset` pulsed while `a_out`=7 -> next cycle all outputs 0 and no `done` pulse. A subsequent start sweeps from A=0 and completes normally.
- `start` re-asserted while `busy`=1 with `b_cfg` changed -> ignored. `b_out` keeps the original value and `done` arrives at the original cycle.

Source files
------------

// File: rtl/reduction_adder_checker_if.sv
// Stimulus/response bus between the sweeper and the reduction-gate and adder
// units it exercises.
//   a_out, b_out : operand vectors driven by the checker
//   and_in, or_in, xor_in : reduction responses of a_out
//   sum_in, carry_in      : adder response of a_out + b_out (carry-in low)
// master = checker side, slave = unit-under-check side.
interface reduction_adder_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             and_in;
  logic             or_in;
  logic             xor_in;
  logic [WIDTH-1:0] sum_in;
  logic             carry_in;

  modport master (
    output a_out, b_out,
    input  and_in, or_in, xor_in, sum_in, carry_in
  );

  modport slave (
    input  a_out, b_out,
    output and_in, or_in, xor_in, sum_in, carry_in
  );
endinterface

// File: rtl/reduction_adder_checker.sv
// Vector sweeper and response checker for the reduction-gate / adder datapath.
// On an accepted start, every A value 0..2^WIDTH-1 is driven with a latched B
// operand; each vector is held SETTLE cycles and then compared in a SAMPLE
// cycle against locally computed AND/OR/XOR reductions and the A+B sum/carry.
//   clk, reset : clock, synchronous active-high reset (clears all outputs)
//   start      : begin a sweep (honoured only while idle)
//   b_cfg      : B operand, captured on accepted start
//   bus        : master side of the stimulus/response interface
//   busy       : sweep in progress
//   done       : one-cycle pulse after the terminal vector is compared
//   pass       : last completed sweep had no failing vector
//   err_count  : number of failing vectors
//   fail_idx   : A value of the first failing vector
//   fail_mask  : {carry, sum, xor, or, and} mismatch bits of the first failure
module reduction_adder_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      b_cfg,
  reduction_adder_checker_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [WIDTH:0]        err_count,
  output logic [WIDTH-1:0]      fail_idx,
  output logic [4:0]            fail_mask
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] A_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] A_LAST   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ERR_ONE  = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Expected adder result, one bit wider so the carry is never lost.
  function automatic logic [WIDTH:0] exp_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Mismatch bits {carry, sum, xor, or, and} of the observed responses.
  function automatic logic [4:0] mismatch(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             r_and,
                                          input logic             r_or,
                                          input logic             r_xor,
                                          input logic [WIDTH-1:0] r_sum,
                                          input logic             r_carry);
    logic [WIDTH:0] s;
    logic [4:0]     m;
    s    = exp_add(a, b);
    m[0] = (r_and   != (&a));
    m[1] = (r_or    != (|a));
    m[2] = (r_xor   != (^a));
    m[3] = (r_sum   != s[WIDTH-1:0]);
    m[4] = (r_carry != s[WIDTH]);
    return m;
  endfunction

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_out_q,     a_out_d;
  logic [WIDTH-1:0] b_out_q,     b_out_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic [WIDTH:0]   err_count_q, err_count_d;
  logic [WIDTH-1:0] fail_idx_q,  fail_idx_d;
  logic [4:0]       fail_mask_q, fail_mask_d;

  logic [4:0]       mism;
  logic [WIDTH:0]   err_next;

  // Compare stage: responses to the currently held vector.
  always_comb begin
    mism     = mismatch(a_out_q, b_out_q, bus.and_in, bus.or_in, bus.xor_in,
                        bus.sum_in, bus.carry_in);
    err_next = (|mism) ? (err_count_q + ERR_ONE) : err_count_q;
  end

  // Sequencer next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_out_d     = b_cfg;
          a_out_d     = '0;
          err_count_d = '0;
          fail_idx_d  = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          cnt_d       = CNT_LOAD;
          busy_d      = 1'b1;
          state_d     = S_DRIVE;
        end
      end

      S_DRIVE: begin
        // The SETTLE-th hold cycle is the one that sees the counter at 1.
        if (cnt_q <= CNT_ONE) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SAMPLE: begin
        err_count_d = err_next;
        if ((|mism) && (err_count_q == '0)) begin
          fail_idx_d  = a_out_q;
          fail_mask_d = mism;
        end
        if (a_out_q == A_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
          state_d = S_DONE;
        end else begin
          a_out_d = a_out_q + A_ONE;
          cnt_d   = CNT_LOAD;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register stage: every output is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_idx_q  <= '0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_idx_q  <= fail_idx_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign bus.a_out = a_out_q;
  assign bus.b_out = b_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_idx  = fail_idx_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_reduction_adder_checker.sv
module tb_reduction_adder_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] b_cfg;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] fail_idx;
  logic [4:0] fail_mask;
  int         fault_mode;

  int nvec;
  int nerr;

  typedef struct {
    logic [4:0] err;
    logic [3:0] idx;
    logic [4:0] mask;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  reduction_adder_checker_if #(.WIDTH(4)) rif ();

  reduction_adder_checker #(.WIDTH(4), .SETTLE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .b_cfg     (b_cfg),
    .bus       (rif),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_idx  (fail_idx),
    .fail_mask (fail_mask)
  );

  // Behavioural units under check, with selectable injected faults:
  // 1 = and stuck 0, 2 = carry stuck 0, 3 = or stuck 1, 4 = sum[0] stuck 1.
  function automatic logic [7:0] resp(input logic [3:0] a, input logic [3:0] b,
                                      input int f);
    logic [4:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = {s[4], s[3:0], ^a, |a, &a};
    case (f)
      1: r[0] = 1'b0;
      2: r[7] = 1'b0;
      3: r[1] = 1'b1;
      4: r[3] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  assign {rif.carry_in, rif.sum_in, rif.xor_in, rif.or_in, rif.and_in} =
    resp(rif.a_out, rif.b_out, fault_mode);

  // Expected sweep outcome: walk every A, diff faulty against ideal.
  function automatic exp_t model(input logic [3:0] b, input int f);
    exp_t       e;
    logic [7:0] r;
    logic [7:0] i;
    logic [4:0] m;
    logic [3:0] a;
    e.err  = '0;
    e.idx  = '0;
    e.mask = '0;
    for (int k = 0; k < 16; k++) begin
      a    = 4'(k);
      r    = resp(a, b, f);
      i    = resp(a, b, 0);
      m[0] = r[0] != i[0];
      m[1] = r[1] != i[1];
      m[2] = r[2] != i[2];
      m[3] = r[6:3] != i[6:3];
      m[4] = r[7] != i[7];
      if (m != 5'b0) begin
        if (e.err == 5'd0) begin
          e.idx  = a;
          e.mask = m;
        end
        e.err = e.err + 5'd1;
      end
    end
    e.pass = (e.err == 5'd0);
    return e;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic [3:0] b, input int f, input bit inject);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    fault_mode = f;
    b_cfg      = b;
    start      = 1'b1;
    sb.push_back(model(b, f));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_eq("busy_e0", 32'(busy), 32'd1);
    chk_eq("a_e0", 32'(rif.a_out), 32'd0);
    chk_eq("b_e0", 32'(rif.b_out), 32'(b));
    chk_eq("err_clr", 32'(err_count), 32'd0);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject && cyc == 10) begin
        start = 1'b1;
        b_cfg = ~b;
      end
      if (inject && cyc == 14) begin
        start = 1'b0;
        b_cfg = b;
      end
      if (cyc == 10) begin
        chk_eq("a_mid", 32'(rif.a_out), 32'd4);
        chk_eq("busy_mid", 32'(busy), 32'd1);
      end
      if (cyc == 15) chk_eq("b_hold", 32'(rif.b_out), 32'(b));
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk_eq("done_cyc", 32'(cyc), 32'd33);
      chk_eq("busy_done", 32'(busy), 32'd0);
      chk_eq("err_count", 32'(err_count), 32'(e.err));
      chk_eq("fail_idx", 32'(fail_idx), 32'(e.idx));
      chk_eq("fail_mask", 32'(fail_mask), 32'(e.mask));
      chk_eq("pass", 32'(pass), 32'(e.pass));
      @(posedge clk);
      #1;
      chk_eq("done_pulse", 32'(done), 32'd0);
      chk_eq("pass_hold", 32'(pass), 32'(e.pass));
      chk_eq("a_hold", 32'(rif.a_out), 32'hF);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_a"}, 32'(rif.a_out), 32'd0);
    chk_eq({tag, "_b"}, 32'(rif.b_out), 32'd0);
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_done"}, 32'(done), 32'd0);
    chk_eq({tag, "_pass"}, 32'(pass), 32'd0);
    chk_eq({tag, "_err"}, 32'(err_count), 32'd0);
    chk_eq({tag, "_idx"}, 32'(fail_idx), 32'd0);
    chk_eq({tag, "_mask"}, 32'(fail_mask), 32'd0);
  endtask

  task automatic reset_mid_sweep();
    int  n;
    bit  hit;
    bit  saw_done;
    @(negedge clk);
    fault_mode = 3;
    b_cfg      = 4'h6;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit   = 1'b0;
    n     = 0;
    while (!hit && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rif.a_out == 4'd7) hit = 1'b1;
    end
    if (!hit) begin
      chk_eq("a7_timeout", 32'd0, 32'd1);
    end else begin
      chk_eq("pre_rst_err", 32'(err_count), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midrst");
      reset = 1'b0;
    end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk_eq("no_done_after_rst", 32'(saw_done), 32'd0);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    nvec       = 0;
    nerr       = 0;
    reset      = 1'b1;
    start      = 1'b0;
    b_cfg      = '0;
    fault_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    run_sweep(4'b1011, 0, 1'b0);
    run_sweep(4'b0000, 1, 1'b0);
    run_sweep(4'b1011, 2, 1'b0);
    run_sweep(4'b0000, 3, 1'b0);
    run_sweep(4'b0000, 4, 1'b0);
    run_sweep(4'b0011, 2, 1'b1);
    reset_mid_sweep();
    run_sweep(4'b1011, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
